// File: rtl/framebuffer_scan_reader_pkg.sv
// Shared geometry defaults, width helpers and FSM encoding for the framebuffer port-B scan reader.
package framebuffer_scan_reader_pkg;

  localparam int DEF_PIXEL_WIDTH      = 64;
  localparam int DEF_PIXEL_HEIGHT     = 32;
  localparam int DEF_PIXEL_HALFHEIGHT = 16;
  localparam int DEF_BYTES_PER_PIXEL  = 3;
  localparam int DEF_READ_LATENCY     = 2;
  localparam int SCAN_FIFO_DEPTH      = 4;

  function automatic int num_address_b_bits(input int w, input int hh);
    return $clog2(w * hh);
  endfunction

  // Port B returns one byte per colour per subpanel for the addressed column.
  function automatic int num_data_b_bits(input int h, input int bpp, input int hh);
    return (h / hh) * bpp * 8;
  endfunction

  function automatic int col_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int row_bits(input int hh);
    return (hh > 1) ? $clog2(hh) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/framebuffer_scan_reader_fifo.sv
// Small synchronous FIFO with asynchronous reset used as the skid buffer for the pixel stream.
module scan_fifo
  import framebuffer_scan_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/framebuffer_scan_reader.sv
// Port-B read sequencer: sweeps one scan row, tracks the fixed read latency and streams each
// all-lane column word downstream through a credit-limited skid FIFO.
module framebuffer_scan_reader
  import framebuffer_scan_reader_pkg::*;
#(
  parameter int PIXEL_WIDTH      = DEF_PIXEL_WIDTH,
  parameter int PIXEL_HEIGHT     = DEF_PIXEL_HEIGHT,
  parameter int PIXEL_HALFHEIGHT = DEF_PIXEL_HALFHEIGHT,
  parameter int BYTES_PER_PIXEL  = DEF_BYTES_PER_PIXEL,
  parameter int READ_LATENCY     = DEF_READ_LATENCY,
  parameter int FIFO_DEPTH       = SCAN_FIFO_DEPTH,
  localparam int AB = num_address_b_bits(PIXEL_WIDTH, PIXEL_HALFHEIGHT),
  localparam int QW = num_data_b_bits(PIXEL_HEIGHT, BYTES_PER_PIXEL, PIXEL_HALFHEIGHT),
  localparam int CB = col_bits(PIXEL_WIDTH),
  localparam int RB = row_bits(PIXEL_HALFHEIGHT)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          row_start_i,
  input  logic [RB-1:0] row_sel_i,
  output logic          busy_o,
  output logic          row_done_o,
  output logic          overrun_o,
  output logic [AB-1:0] mem_addr_b_o,
  output logic          mem_ce_b_o,
  input  logic [QW-1:0] mem_q_b_i,
  output logic          pix_valid_o,
  input  logic          pix_ready_i,
  output logic [QW-1:0] pix_data_o,
  output logic [CB-1:0] pix_col_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CB-1:0] LAST_COL = CB'(PIXEL_WIDTH - 1);

  scan_state_e   state_q, state_d;
  logic [RB-1:0] row_q, row_d;
  logic [CB-1:0] col_q, col_d;
  logic          overrun_q, overrun_d;

  logic [READ_LATENCY-1:0] tag_q;
  logic [CB-1:0]           tag_col_q [READ_LATENCY];

  logic          issue;
  logic          push;
  logic          pop;
  logic          row_done;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW:0]   occupancy;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(tag_q[i]);
  end

  assign pop  = pix_valid_o && pix_ready_i;
  assign push = tag_q[READ_LATENCY-1];

  // Slots promised to the FIFO; a head leaving this cycle already counts as a free slot.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight} - (CW + 1)'(pop);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    overrun_d = overrun_q;
    issue     = 1'b0;
    row_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (row_start_i) begin
          row_d   = row_sel_i;
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (occupancy < (CW + 1)'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (col_q == LAST_COL) state_d = DRAIN;
          else                   col_d   = col_q + 1'b1;
        end
      end
      DRAIN: begin
        if (pop && (pix_col_o == LAST_COL)) begin
          row_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (row_start_i && (state_q != IDLE)) overrun_d = 1'b1;
  end

  // The tag pipeline mirrors port B: a tag leaving the last stage means mem_q_b_i holds that column.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      overrun_q <= 1'b0;
      tag_q     <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_col_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      overrun_q    <= overrun_d;
      tag_q[0]     <= issue;
      tag_col_q[0] <= col_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i]     <= tag_q[i-1];
        tag_col_q[i] <= tag_col_q[i-1];
      end
    end
  end

  scan_fifo #(
    .WIDTH(CB + QW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (push),
    .data_i ({tag_col_q[READ_LATENCY-1], mem_q_b_i}),
    .pop_i  (pop),
    .data_o ({pix_col_o, pix_data_o}),
    .count_o(fifo_count),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (reset_i) !(push && fifo_full));

  assign pix_valid_o  = !fifo_empty;
  assign busy_o       = (state_q != IDLE);
  assign row_done_o   = row_done;
  assign overrun_o    = overrun_q;
  assign mem_ce_b_o   = (state_q != IDLE) || (inflight != '0);
  assign mem_addr_b_o = AB'(int'(row_q) * PIXEL_WIDTH + int'(col_q));

endmodule

// File: tb/tb_framebuffer_scan_reader.sv
// Self-checking bench: a port-B memory model feeds the reader and a queue-based row model checks the stream.
module tb_framebuffer_scan_reader;

  localparam int W     = 64;
  localparam int HH    = 16;
  localparam int QW    = 48;
  localparam int AB    = 10;
  localparam int CB    = 6;
  localparam int RB    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          row_start;
  logic [RB-1:0] row_sel;
  logic          busy, row_done, overrun;
  logic [AB-1:0] mem_addr_b;
  logic          mem_ce_b;
  logic [QW-1:0] mem_q_b;
  logic          pix_valid, pix_ready;
  logic [QW-1:0] pix_data;
  logic [CB-1:0] pix_col;

  always #5 clk = ~clk;

  framebuffer_scan_reader dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .row_start_i (row_start),
    .row_sel_i   (row_sel),
    .busy_o      (busy),
    .row_done_o  (row_done),
    .overrun_o   (overrun),
    .mem_addr_b_o(mem_addr_b),
    .mem_ce_b_o  (mem_ce_b),
    .mem_q_b_i   (mem_q_b),
    .pix_valid_o (pix_valid),
    .pix_ready_i (pix_ready),
    .pix_data_o  (pix_data),
    .pix_col_o   (pix_col)
  );

  // Port B of the framebuffer: two register stages, advancing only while ClockEnB is high.
  logic [QW-1:0] mem [W*HH];
  logic [QW-1:0] memP1, memQ;
  always @(posedge clk) if (mem_ce_b) begin
    memP1 <= mem[mem_addr_b];
    memQ  <= memP1;
  end
  assign mem_q_b = memQ;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            col;
    logic [QW-1:0] data;
  } beat_t;

  beat_t         expQ[$];
  bit            mBusy = 0;
  bit            mOverrun = 0;
  int            curRow = 0;
  int            beatCount = 0;
  int            donePulses = 0;
  int            startCyc = 0, firstValidCyc = -1, doneCyc = -1;
  int            firstAddr = -1, maxAddr = -1;
  bit            holdPending = 0;
  logic [QW-1:0] holdData;
  logic [CB-1:0] holdCol;

  // Reference model: an accepted row is the ordered list of its W memory words; every handshake pops one.
  always @(negedge clk) begin
    bit accept, wasBusy, expDone;
    if (reset) begin
      expQ.delete();
      mBusy = 0;
      mOverrun = 0;
      holdPending = 0;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_row_done", row_done, 0);
      checkOutput("rst_overrun", overrun, 0);
      checkOutput("rst_ce", mem_ce_b, 0);
      checkOutput("rst_addr", mem_addr_b, 0);
      checkOutput("rst_valid", pix_valid, 0);
      checkOutput("rst_data", pix_data, 0);
      checkOutput("rst_col", pix_col, 0);
    end else begin
      accept  = pix_valid && pix_ready;
      wasBusy = mBusy;
      checkOutput("busy", busy, mBusy);
      checkOutput("overrun", overrun, mOverrun);
      if (expQ.size() == 0) checkOutput("stale_valid", pix_valid, 0);
      if (holdPending) begin
        checkOutput("hold_valid", pix_valid, 1);
        checkOutput("hold_data", pix_data, holdData);
        checkOutput("hold_col", pix_col, holdCol);
      end
      if (mBusy) begin
        checkOutput("ce_busy", mem_ce_b, 1);
        checkOutput("addr_row", int'(mem_addr_b) / W, curRow);
        checkOutput("outstanding", (int'(mem_addr_b) % W - beatCount) <= DEPTH, 1);
        if (cyc == startCyc + 1) firstAddr = int'(mem_addr_b);
        if (int'(mem_addr_b) > maxAddr) maxAddr = int'(mem_addr_b);
        if (pix_valid && firstValidCyc < 0) firstValidCyc = cyc;
      end
      expDone = accept && (expQ.size() == 1);
      if (accept) begin
        if (expQ.size() == 0) begin
          checkOutput("extra_beat", 1, 0);
        end else begin
          checkOutput("beat_col", pix_col, expQ[0].col);
          checkOutput("beat_data", pix_data, expQ[0].data);
          void'(expQ.pop_front());
          beatCount++;
        end
      end
      checkOutput("row_done", row_done, expDone);
      if (row_done) donePulses++;
      if (expDone) begin
        doneCyc = cyc;
        mBusy = 0;
      end
      if (row_start) begin
        if (wasBusy) mOverrun = 1;
        else begin
          curRow = int'(row_sel);
          for (int c = 0; c < W; c++) expQ.push_back('{c, mem[curRow*W + c]});
          mBusy = 1;
          startCyc = cyc;
          beatCount = 0;
          donePulses = 0;
          firstValidCyc = -1;
          doneCyc = -1;
          firstAddr = -1;
          maxAddr = -1;
        end
      end
      holdPending = pix_valid && !pix_ready;
      holdData = pix_data;
      holdCol = pix_col;
    end
  end

  // 0: always ready, 1: random, 2: toggle, 3: stall 20 cycles after beat 1.
  int readyMode = 0;
  int stallLeft = 0;
  bit stallDone = 0;
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        1: pix_ready = 1'($urandom_range(0, 1));
        2: pix_ready = ~pix_ready;
        3: begin
          if (stallLeft > 0) begin
            pix_ready = 1'b0;
            stallLeft--;
          end else if (beatCount == 2 && !stallDone) begin
            pix_ready = 1'b0;
            stallLeft = 19;
            stallDone = 1;
          end else pix_ready = 1'b1;
        end
        default: pix_ready = 1'b1;
      endcase
    end
  end

  task automatic applyStimulus(input int row);
    @(posedge clk);
    #1;
    row_start = 1'b1;
    row_sel   = RB'(row);
    @(posedge clk);
    #1;
    row_start = 1'b0;
  endtask

  task automatic waitRowDone(input int budget);
    int n = 0;
    while (mBusy && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("row_timeout", mBusy, 0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    row_start = 1'b0;
    row_sel   = '0;
    for (int i = 0; i < W*HH; i++) mem[i] = {16'($urandom), $urandom};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Row 3 unthrottled: pins address, first-beat latency and row length.
    applyStimulus(3);
    waitRowDone(300);
    checkOutput("t1_first_addr", firstAddr, 192);
    checkOutput("t1_last_addr", maxAddr, 255);
    checkOutput("t1_first_valid", firstValidCyc - startCyc, 4);
    checkOutput("t1_done_cycle", doneCyc - startCyc, 67);
    checkOutput("t1_beats", beatCount, 64);

    // Twenty-cycle stall after beat 1.
    readyMode = 3;
    applyStimulus(7);
    waitRowDone(500);
    checkOutput("t2_beats", beatCount, 64);
    checkOutput("t2_stalled", stallDone, 1);

    // Random backpressure over ten random rows.
    readyMode = 1;
    for (int r = 0; r < 10; r++) begin
      applyStimulus($urandom_range(0, HH - 1));
      waitRowDone(1000);
      checkOutput("t3_beats", beatCount, 64);
    end
    checkOutput("t3_overrun", overrun, 0);

    // Overlapping request during FETCH of row 5.
    readyMode = 0;
    applyStimulus(5);
    repeat (10) @(posedge clk);
    applyStimulus(9);
    waitRowDone(300);
    @(posedge clk);
    #1;
    checkOutput("t4_overrun", overrun, 1);
    checkOutput("t4_beats", beatCount, 64);
    checkOutput("t4_busy", busy, 0);

    // Reset in the middle of row 2, then a clean row 0.
    applyStimulus(2);
    n = 0;
    while (beatCount < 30 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checkOutput("t5_reach_beat30", beatCount, 30);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_valid", pix_valid, 0);
    checkOutput("t5_ce", mem_ce_b, 0);
    checkOutput("t5_overrun", overrun, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(0);
    waitRowDone(300);
    checkOutput("t5_first_addr", firstAddr, 0);
    checkOutput("t5_beats", beatCount, 64);
    checkOutput("t5_done_cycle", doneCyc - startCyc, 67);

    // Last scan row with ready toggling every cycle.
    readyMode = 2;
    applyStimulus(HH - 1);
    waitRowDone(600);
    checkOutput("t6_first_addr", firstAddr, 960);
    checkOutput("t6_last_addr", maxAddr, 1023);
    checkOutput("t6_beats", beatCount, 64);
    checkOutput("t6_done_pulses", donePulses, 1);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
